// File: rtl/fp_pkg.sv
// Shared floating-point constants, flag bit positions and special-value builders.
package fp_pkg;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;

  localparam int unsigned FLAGS_W       = 3;
  localparam int unsigned FLAG_INEXACT  = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_INVALID  = 2;

  // Canonical quiet NaN {0, all-ones, 1 0..0}; callers truncate to their width.
  function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
    return (((64'(1) << exp_w) - 64'(1)) << man_w) | (64'(1) << (man_w - 1));
  endfunction

  function automatic logic [63:0] inf_bits(input logic sign, input int unsigned exp_w,
                                           input int unsigned man_w);
    return (64'(sign) << (exp_w + man_w)) | (((64'(1) << exp_w) - 64'(1)) << man_w);
  endfunction

endpackage

// File: rtl/lzc.sv
// Combinational leading-zero counter; returns WIDTH when the input is all zeros.
module lzc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]               i_data,
  output logic [$clog2(WIDTH + 1)-1:0]   o_cnt_c
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit wins.
  always_comb begin
    o_cnt_c = CW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_data[i]) o_cnt_c = CW'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Five-stage flush-to-zero floating-point adder/subtractor, RNE rounding, valid/ready flow.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic                     op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [FLAGS_W-1:0]       flags
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned W1  = W - 1;
  localparam int unsigned X   = MAN_W + 4;
  localparam int unsigned S   = MAN_W + 5;
  localparam int unsigned E2  = EXP_W + 2;
  localparam int unsigned MW2 = MAN_W + 2;
  localparam int unsigned LZW = MAN_W + 2;
  localparam int unsigned CW  = $clog2(LZW + 1);
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN   = W'(qnan_bits(EXP_W, MAN_W));

  logic r1_v, r2_v, r3_v, r4_v, r_out_valid;
  logic [W-1:0] r_result;
  logic [FLAGS_W-1:0] r_flags;
  // Special-case bundle {is_special, invalid, result} rides alongside the datapath.
  logic [W+1:0] r1_sp, r2_sp, r3_sp, r4_sp;
  logic r1_sa, r1_sb, r2_sl, r2_ss, r3_sub, r3_s, r3_zs, r4_s, r4_zs;
  logic [EXP_W-1:0] r1_ea, r1_eb, r2_e, r2_diff, r3_e, r4_e;
  logic [MAN_W:0] r1_ma, r1_mb, r2_ml, r2_ms;
  logic [X-1:0] r3_big, r3_small;
  logic [S-1:0] r4_sum;

  logic w_adv, w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_snan, w_b_snan;
  logic w1_spec, w1_inv;
  logic [W-1:0] w1_res;
  logic w2_swap;
  logic [EXP_W-1:0] w3_sh;
  logic [X-1:0] w3_ext, w3_shr;
  logic w3_lost;
  logic [S-1:0] w4_sum;
  logic [CW-1:0] w5_cnt;
  logic [X-1:0] w5_n;
  logic [E2-1:0] w5_e;
  logic [MW2-1:0] w5_m;
  logic [MAN_W-1:0] w5_frac;
  logic w5_inx, w5_up;
  logic [W-1:0] w5_res;
  logic [FLAGS_W-1:0] w5_flags;

  // Whole pipe holds while a finished result is waiting on the consumer.
  assign w_adv     = !(r_out_valid && !out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  // Stage 1: unpack; subtraction is addition with b's sign flipped.
  assign {w_sa, w_ea, w_fa} = a;
  assign w_sb     = b[W-1] ^ op;
  assign w_eb     = b[W-2:MAN_W];
  assign w_fb     = b[MAN_W-1:0];
  assign w_a_nan  = (w_ea == EMAX) && (w_fa != '0);
  assign w_b_nan  = (w_eb == EMAX) && (w_fb != '0);
  assign w_a_inf  = (w_ea == EMAX) && (w_fa == '0);
  assign w_b_inf  = (w_eb == EMAX) && (w_fb == '0);
  assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];

  always_comb begin
    w1_spec = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
    w1_inv  = 1'b0;
    w1_res  = QNAN;
    if (w_a_nan || w_b_nan)                        w1_inv = w_a_snan | w_b_snan;
    else if (w_a_inf && w_b_inf && (w_sa != w_sb)) w1_inv = 1'b1;
    else if (w_a_inf)                              w1_res = W'(inf_bits(w_sa, EXP_W, MAN_W));
    else if (w_b_inf)                              w1_res = W'(inf_bits(w_sb, EXP_W, MAN_W));
  end

  // Stage 2 picks the larger magnitude; stage 3 aligns the smaller with sticky collection.
  assign w2_swap = {r1_eb, r1_mb} > {r1_ea, r1_ma};
  assign w3_sh   = (r2_diff > SH_MAX) ? SH_MAX : r2_diff;
  assign w3_ext  = {r2_ms, 3'b000};
  assign w3_shr  = w3_ext >> w3_sh;
  assign w3_lost = |(w3_ext & ((X'(1) << w3_sh) - X'(1)));
  assign w4_sum  = r3_sub ? ({1'b0, r3_big} - {1'b0, r3_small})
                          : ({1'b0, r3_big} + {1'b0, r3_small});

  lzc #(.WIDTH(LZW)) u_lzc (
    .i_data  (r4_sum[MAN_W+3:2]),
    .o_cnt_c (w5_cnt)
  );

  // Stage 5: normalise, round to nearest even, classify and pack.
  always_comb begin
    w5_n = r4_sum[X-1:0] << w5_cnt;
    w5_e = {2'b00, r4_e} - E2'(w5_cnt);
    if (r4_sum[S-1]) begin
      w5_n = {r4_sum[S-1:2], r4_sum[1] | r4_sum[0]};
      w5_e = {2'b00, r4_e} + E2'(1);
    end
    w5_inx  = |w5_n[2:0];
    w5_up   = w5_n[2] & (w5_n[3] | w5_n[1] | w5_n[0]);
    w5_m    = {1'b0, w5_n[X-1:3]} + MW2'(w5_up);
    w5_frac = w5_m[MAN_W-1:0];
    if (w5_m[MAN_W+1]) begin
      w5_e    = w5_e + E2'(1);
      w5_frac = w5_m[MAN_W:1];
    end
    w5_flags = '0;
    w5_res   = {r4_s, w5_e[EXP_W-1:0], w5_frac};
    if (r4_sp[W+1]) begin
      w5_res = r4_sp[W-1:0];
      w5_flags[FLAG_INVALID] = r4_sp[W];
    end else if (r4_sum == '0) begin
      w5_res = {r4_zs, {W1{1'b0}}};
    end else if (!w5_e[E2-1] && (w5_e[E2-2:0] >= (E2-1)'(EMAX))) begin
      w5_res = W'(inf_bits(r4_s, EXP_W, MAN_W));
      w5_flags[FLAG_OVERFLOW] = 1'b1;
      w5_flags[FLAG_INEXACT]  = 1'b1;
    end else if (w5_e[E2-1] || (w5_e == '0)) begin
      w5_res = {r4_s, {W1{1'b0}}};
      w5_flags[FLAG_INEXACT] = w5_inx;
    end else begin
      w5_flags[FLAG_INEXACT] = w5_inx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v        <= 1'b0;
      r2_v        <= 1'b0;
      r3_v        <= 1'b0;
      r4_v        <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_adv) begin
      r1_v        <= in_valid;
      r2_v        <= r1_v;
      r3_v        <= r2_v;
      r4_v        <= r3_v;
      r_out_valid <= r4_v;
      if (r4_v) begin
        r_result <= w5_res;
        r_flags  <= w5_flags;
      end
    end
  end

  // Datapath registers are unreset; only valid-qualified data ever reaches result.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_sa    <= w_sa;
      r1_ea    <= w_ea;
      r1_ma    <= (w_ea == '0) ? '0 : {1'b1, w_fa};
      r1_sb    <= w_sb;
      r1_eb    <= w_eb;
      r1_mb    <= (w_eb == '0) ? '0 : {1'b1, w_fb};
      r1_sp    <= {w1_spec, w1_inv, w1_res};
      r2_sl    <= w2_swap ? r1_sb : r1_sa;
      r2_ss    <= w2_swap ? r1_sa : r1_sb;
      r2_e     <= w2_swap ? r1_eb : r1_ea;
      r2_ml    <= w2_swap ? r1_mb : r1_ma;
      r2_ms    <= w2_swap ? r1_ma : r1_mb;
      r2_diff  <= w2_swap ? (r1_eb - r1_ea) : (r1_ea - r1_eb);
      r2_sp    <= r1_sp;
      r3_big   <= {r2_ml, 3'b000};
      r3_small <= {w3_shr[X-1:1], w3_shr[0] | w3_lost};
      r3_sub   <= r2_sl ^ r2_ss;
      r3_s     <= r2_sl;
      r3_zs    <= r2_sl & r2_ss;
      r3_e     <= r2_e;
      r3_sp    <= r2_sp;
      r4_sum   <= w4_sum;
      r4_s     <= r3_s;
      r4_zs    <= r3_zs;
      r4_e     <= r3_e;
      r4_sp    <= r3_sp;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: single and half precision instances.
module tb_fp_addsub_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [2:0]  f;
  } hvec_t;

  localparam int NV = 17;
  // Hand-derived known answers; flags are {invalid, overflow, inexact}.
  vec_t vt [NV] = '{
    '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000},
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000},
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001},
    '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 3'b001},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011},
    '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100},
    '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000},
    '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000},
    '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000},
    '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100},
    '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000},
    '{32'h80C00000, 32'h80800000, 1'b1, 32'h80000000, 3'b000},
    '{32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 3'b000},
    '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001},
    '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001},
    '{32'h7F7FFFFF, 32'h73800000, 1'b0, 32'h7F800000, 3'b011}
  };

  hvec_t hv [2] = '{
    '{16'h3C00, 16'h3C00, 16'h4000, 3'b000},
    '{16'h7BFF, 16'h7BFF, 16'h7C00, 3'b011}
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sp_in_valid = 1'b0, sp_in_ready, sp_op = 1'b0;
  logic [31:0] sp_a = '0, sp_b = '0, sp_result;
  logic        sp_out_valid, sp_out_ready = 1'b1;
  logic [2:0]  sp_flags;
  logic        hp_in_valid = 1'b0, hp_in_ready, hp_op = 1'b0;
  logic [15:0] hp_a = '0, hp_b = '0, hp_result;
  logic        hp_out_valid, hp_out_ready = 1'b1;
  logic [2:0]  hp_flags;

  logic [34:0] sp_q[$];
  logic [18:0] hp_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  logic        stall_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [34:0] held = '0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (
    .clk(clk), .rst_n(rst_n), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
    .a(sp_a), .b(sp_b), .op(sp_op), .out_valid(sp_out_valid), .out_ready(sp_out_ready),
    .result(sp_result), .flags(sp_flags)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst_n(rst_n), .in_valid(hp_in_valid), .in_ready(hp_in_ready),
    .a(hp_a), .b(hp_b), .op(hp_op), .out_valid(hp_out_valid), .out_ready(hp_out_ready),
    .result(hp_result), .flags(hp_flags)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_sp(input int idx);
    int n;
    @(negedge clk);
    sp_a = vt[idx].a;
    sp_b = vt[idx].b;
    sp_op = vt[idx].op;
    sp_in_valid = 1'b1;
    #1;
    n = 0;
    while (!sp_in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("sp_accept", 64'(sp_in_ready), 64'(1));
    if (sp_in_ready) sp_q.push_back({vt[idx].r, vt[idx].f});
    @(posedge clk);
    #1;
    sp_in_valid = 1'b0;
  endtask

  task automatic send_hp(input int idx);
    @(negedge clk);
    hp_a = hv[idx].a;
    hp_b = hv[idx].b;
    hp_in_valid = 1'b1;
    #1;
    check_eq("hp_accept", 64'(hp_in_ready), 64'(1));
    if (hp_in_ready) hp_q.push_back({hv[idx].r, hv[idx].f});
    @(posedge clk);
    #1;
    hp_in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    #2;
    if (stall_en) sp_out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: stall stability and in-order completion for the single-precision instance.
  always @(negedge clk) begin
    logic [34:0] e;
    #1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && sp_out_valid) check_eq("sp_stall_hold", 64'({sp_result, sp_flags}), 64'(held));
      prev_stall = sp_out_valid && !sp_out_ready;
      held = {sp_result, sp_flags};
      if (sp_out_valid && sp_out_ready) begin
        if (sp_q.size() == 0) begin
          check_eq("sp_unexpected_out", 64'(sp_result), 64'(0));
          check_eq("sp_unexpected_valid", 64'(sp_out_valid), 64'(0));
        end else begin
          e = sp_q.pop_front();
          check_eq("sp_result", 64'(sp_result), 64'(e[34:3]));
          check_eq("sp_flags", 64'(sp_flags), 64'(e[2:0]));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [18:0] e;
    #1;
    if (rst_n && hp_out_valid && hp_out_ready) begin
      if (hp_q.size() == 0) begin
        check_eq("hp_unexpected_valid", 64'(hp_out_valid), 64'(0));
      end else begin
        e = hp_q.pop_front();
        check_eq("hp_result", 64'(hp_result), 64'(e[18:3]));
        check_eq("hp_flags", 64'(hp_flags), 64'(e[2:0]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int stale;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(sp_out_valid), 64'(0));
    check_eq("rst_result", 64'(sp_result), 64'(0));
    check_eq("rst_flags", 64'(sp_flags), 64'(0));
    check_eq("rst_hp_out_valid", 64'(hp_out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("in_ready_after_rst", 64'(sp_in_ready), 64'(1));

    // Latency: accepting edge plus four more edges brings out_valid up.
    @(negedge clk);
    sp_a = vt[0].a;
    sp_b = vt[0].b;
    sp_op = vt[0].op;
    sp_in_valid = 1'b1;
    sp_q.push_back({vt[0].r, vt[0].f});
    @(posedge clk);
    #1;
    sp_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("latency_early", 64'(sp_out_valid), 64'(0));
    @(posedge clk);
    #1;
    check_eq("latency_5", 64'(sp_out_valid), 64'(1));

    for (int i = 1; i < NV; i++) send_sp(i);

    stall_en = 1'b1;
    for (int i = 0; i < 20; i++) send_sp(int'($urandom_range(0, NV - 1)));
    stall_en = 1'b0;
    sp_out_ready = 1'b1;
    n = 0;
    while (sp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq("sp_drain_left", 64'(sp_q.size()), 64'(0));

    // Reset with three operations in flight, the oldest stalled at the output.
    @(negedge clk);
    sp_out_ready = 1'b0;
    send_sp(0);
    send_sp(2);
    send_sp(3);
    n = 0;
    while (!sp_out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("pre_rst_out_valid", 64'(sp_out_valid), 64'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_out_valid", 64'(sp_out_valid), 64'(0));
    check_eq("rst_async_result", 64'(sp_result), 64'(0));
    sp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sp_out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (sp_out_valid) stale++;
    end
    check_eq("no_stale_after_rst", 64'(stale), 64'(0));

    send_hp(0);
    send_hp(1);
    n = 0;
    while (hp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq("hp_drain_left", 64'(hp_q.size()), 64'(0));
    check_eq("sp_queue_end", 64'(sp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand pair valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have ports a and b, input, W each, IEEE-style operands {sign, exp, frac}.
REQ-008 SHALL have port op, input, 1: 0 = a+b, 1 = a-b.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port result, output, W, rounded sum.
REQ-012 SHALL have port flags, output, 3: {invalid, overflow, inexact}, qualified by out_valid.

Function
REQ-013 SHALL accept a transaction when in_valid && in_ready, and deliver it when out_valid && out_ready.
REQ-014 SHALL have a fixed 5-stage pipeline: unpack/special detect; align swap and exponent difference; shift with guard/round/sticky; add/subtract; normalise, round, pack.
REQ-015 Latency SHALL be 5 cycles from acceptance to out_valid when there is no stall.
REQ-016 The pipeline SHALL advance only when !(out_valid && !out_ready); otherwise all stages hold, and in_ready = advance.
REQ-017 Each stage SHALL carry its own valid bit; bubbles SHALL propagate, and full throughput SHALL be one op per cycle.
REQ-018 Subtract SHALL be implemented as an add with b's sign inverted.
REQ-019 Operands with exp=0 SHALL be treated as signed zero (flush-to-zero); denormal results SHALL flush to zero with the correct sign.
REQ-020 The alignment shift SHALL saturate at MAN_W+3; bits shifted out SHALL OR into sticky.
REQ-021 Rounding SHALL be round-to-nearest-even; a rounding carry SHALL renormalise and increment the exponent.
REQ-022 Normalisation SHALL use a leading-zero count over MAN_W+2 bits and shift left, with the exponent decremented by the count.
REQ-023 An exact zero result SHALL be +0, except that (-0)+(-0) SHALL give -0.
REQ-024 An exponent at or above all-ones after rounding SHALL give ±infinity with overflow=1 and inexact=1.
REQ-025 A NaN operand, or inf-inf of opposite effective sign, SHALL give canonical quiet NaN {0, all-ones, 1 followed by zeros}; invalid SHALL be 1 only for inf-inf or signalling NaN.
REQ-026 inf plus a finite value SHALL give that inf with no flags.
REQ-027 inexact SHALL be 1 when guard|round|sticky is nonzero before rounding.
REQ-028 result and flags SHALL remain stable while out_valid && !out_ready.

Reset
REQ-029 On rst_n low, all stage valid bits, out_valid, result and flags SHALL clear to 0 immediately; in_ready SHALL be 1 once released.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations, and none SHALL emerge after release.
REQ-031 Datapath registers other than valids MAY be left unreset, but SHALL NOT cause X on result while out_valid=0.

Structure
REQ-032 Shared package fp_pkg SHALL hold the flag bit indices, the canonical-NaN and infinity builder functions, and the default EXP_W/MAN_W constants.
REQ-033 The leading-zero counter SHALL be a sub-module, lzc, parameterised by width, combinational, with output width $clog2(width+1).
REQ-034 The block SHALL instantiate cleanly at EXP_W=5/MAN_W=10 (half) and at 8/23 (single).

Verification
REQ-035 3F800000 + 3F800000, op=0 -> 40000000 at cycle 5, flags=000.
REQ-036 3F800000 - 3F800000, op=1 -> 00000000; 3F800000 + 33800000 -> 3F800000 with inexact (tie to even); 3F800000 + 34400000 -> 3F800002 with inexact.
REQ-037 7F7FFFFF + 7F7FFFFF -> 7F800000, flags=011; 7F800000 + FF800000 -> 7FC00000, flags=100.
REQ-038 Back-to-back stream of 20 ops with out_ready toggled randomly -> in-order results, none lost or duplicated, result stable during stall.
REQ-039 rst_n pulsed with 3 ops in flight -> out_valid=0 immediately and no stale output after release.
REQ-040 Half-precision instance: 3C00 + 3C00 -> 4000; 7BFF + 7BFF -> 7C00 with overflow.
